// File: rtl/cmd_exec.sv
// Two-state command executor: accepts a 32-bit word, decodes it on the next cycle, and updates the bank/output registers or flags an error.
// Optional rejected-command counter enabled by defining CMD_EXEC_ERR_CNT_EN.
module cmd_exec #(
    parameter int NUM_BANKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_data,
    output logic [NUM_BANKS*8-1:0] bank_val,
    output logic [NUM_BANKS-1:0]   bank_upd,
    output logic [4:0]             out_sel,
    output logic                   out_upd,
    output logic                   err,
    output logic [15:0]            err_cnt
);

    typedef enum logic {IDLE, EXEC} state_t;

    // Enable bits at or above NUM_BANKS address banks that do not exist.
    localparam logic [3:0] EN_LEGAL = 4'((1 << NUM_BANKS) - 1);

    state_t               state_reg, state_next;
    logic [31:0]          cmd_reg;
    logic [7:0]           bank_reg [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_upd_reg;
    logic [NUM_BANKS-1:0] bank_wr_next;
    logic [4:0]           out_sel_reg;
    logic                 out_upd_reg, out_wr_next;
    logic                 err_reg, err_next;
    logic                 bank_ok, out_ok;

    assign cmd_ready = (state_reg == IDLE);

    assign bank_ok = (cmd_reg[27:16] == 12'd0) && (cmd_reg[7:4] == 4'd0)
                  && ((cmd_reg[3:0] & ~EN_LEGAL) == 4'd0);
    assign out_ok  = (cmd_reg[27:5] == 23'd0);

    always_comb begin
        state_next   = state_reg;
        bank_wr_next = '0;
        out_wr_next  = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = IDLE;
                if (cmd_reg[31:28] == 4'h0 && bank_ok) begin
                    bank_wr_next = cmd_reg[NUM_BANKS-1:0];
                end else if (cmd_reg[31:28] == 4'h1 && out_ok) begin
                    out_wr_next = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            cmd_reg <= cmd_data;
        end
    end

    // Reset takes priority, so a word sitting in EXEC is dropped without effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_upd_reg <= '0;
            out_sel_reg  <= 5'd0;
            out_upd_reg  <= 1'b0;
            err_reg      <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_reg[i] <= 8'd0;
            end
        end else begin
            bank_upd_reg <= bank_wr_next;
            out_upd_reg  <= out_wr_next;
            err_reg      <= err_next;
            if (out_wr_next) begin
                out_sel_reg <= cmd_reg[4:0];
            end
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (bank_wr_next[i]) begin
                    bank_reg[i] <= cmd_reg[15:8];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_out
            assign bank_val[gi*8 +: 8] = bank_reg[gi];
        end
    endgenerate

    assign bank_upd = bank_upd_reg;
    assign out_sel  = out_sel_reg;
    assign out_upd  = out_upd_reg;
    assign err      = err_reg;

`ifdef CMD_EXEC_ERR_CNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= 16'd0;
        end else if (err_next && err_cnt_reg != 16'hFFFF) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cmd_exec.sv
// Bench for cmd_exec: directed scenarios plus randomized commands against a behavioural model.
// A second instance with NUM_BANKS=2 covers the narrow-bank rejection rule.
module tb_cmd_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic [31:0] bank_val;
    logic [3:0]  bank_upd;
    logic [4:0]  out_sel;
    logic        out_upd;
    logic        err;
    logic [15:0] err_cnt;

    logic        c2_valid;
    logic        c2_ready;
    logic [31:0] c2_data;
    logic [15:0] c2_bank_val;
    logic [1:0]  c2_bank_upd;
    logic [4:0]  c2_out_sel;
    logic        c2_out_upd;
    logic        c2_err;
    logic [15:0] c2_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the four-bank instance.
    logic [7:0] m_bank [4];
    logic [4:0] m_out;
    int         m_errs;

    always #5 clk = ~clk;

    cmd_exec #(.NUM_BANKS(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .bank_val(bank_val), .bank_upd(bank_upd),
        .out_sel(out_sel), .out_upd(out_upd), .err(err), .err_cnt(err_cnt)
    );

    cmd_exec #(.NUM_BANKS(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_data(c2_data), .bank_val(c2_bank_val), .bank_upd(c2_bank_upd),
        .out_sel(c2_out_sel), .out_upd(c2_out_upd), .err(c2_err), .err_cnt(c2_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 = valid BANK, 1 = valid OUT, 2 = rejected.
    function automatic int classify(input logic [31:0] w, input int nb);
        int id;
        id = int'(w >> 28);
        if (id == 0 && (w & 32'h0FFF_00F0) == 0 && ((w & 32'hF) >> nb) == 0) return 0;
        if (id == 1 && (w & 32'h0FFF_FFE0) == 0) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] model_banks();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 4; i++) v = v | (32'(m_bank[i]) << (8 * i));
        return v;
    endfunction

    function automatic logic [15:0] model_err_cnt();
`ifdef CMD_EXEC_ERR_CNT_EN
        return (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_bank[i] = 8'd0;
        m_out  = 5'd0;
        m_errs = 0;
    endtask

    task automatic model_apply(input logic [31:0] w, output logic [3:0] e_upd,
                               output logic e_oupd, output logic e_err);
        int k;
        k = classify(w, 4);
        e_upd  = 4'd0;
        e_oupd = 1'b0;
        e_err  = 1'b0;
        if (k == 0) begin
            e_upd = w[3:0];
            for (int i = 0; i < 4; i++) if (w[i]) m_bank[i] = w[15:8];
        end else if (k == 1) begin
            e_oupd = 1'b1;
            m_out  = w[4:0];
        end else begin
            e_err = 1'b1;
            m_errs++;
        end
    endtask

    task automatic check_outputs(input logic [3:0] e_upd, input logic e_oupd, input logic e_err);
        check("bank_upd", 32'(bank_upd), 32'(e_upd));
        check("out_upd", 32'(out_upd), 32'(e_oupd));
        check("err", 32'(err), 32'(e_err));
        check("bank_val", bank_val, model_banks());
        check("out_sel", 32'(out_sel), 32'(m_out));
        check("err_cnt", 32'(err_cnt), 32'(model_err_cnt()));
    endtask

    // Issues one word, checks the N+2 result and that all pulses drop at N+3.
    task automatic send(input logic [31:0] w);
        logic [3:0] e_upd;
        logic       e_oupd, e_err;
        int         guard;
        guard = 0;
        while (!cmd_ready && guard < 10) begin
            tick();
            guard++;
        end
        check("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = w;
        tick();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_data  = $urandom;
        check("ready_exec", 32'(cmd_ready), 32'd0);
        tick();
        cmd_valid = 1'b0;
        model_apply(w, e_upd, e_oupd, e_err);
        check_outputs(e_upd, e_oupd, e_err);
        tick();
        check("pulses_clear", {27'd0, bank_upd, out_upd}, 32'd0);
        check("err_clear", 32'(err), 32'd0);
    endtask

    task automatic send2(input logic [31:0] w, input logic [1:0] e_upd, input logic e_err);
        c2_valid = 1'b1;
        c2_data  = w;
        tick();
        c2_valid = 1'b0;
        tick();
        check("nb2_bank_upd", 32'(c2_bank_upd), 32'(e_upd));
        check("nb2_err", 32'(c2_err), 32'(e_err));
        check("nb2_out_upd", 32'(c2_out_upd), 32'd0);
        tick();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 5))
            0: w = {4'h0, 12'h000, 8'($urandom), 4'h0, 4'($urandom)};
            1: w = {4'h0, 12'h000, 8'($urandom), 4'h0, 4'($urandom)} | (32'd1 << (($urandom_range(0, 1) == 0) ? $urandom_range(4, 7) : $urandom_range(16, 27)));
            2: w = {4'h1, 23'd0, 5'($urandom)};
            3: w = {4'h1, 23'd0, 5'($urandom)} | (32'd1 << $urandom_range(5, 27));
            4: w = {4'($urandom_range(2, 15)), 28'($urandom)};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] tp_words [4];
        logic [3:0]  e_upd;
        logic        e_oupd, e_err;
        logic [31:0] first_banks;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 32'd0;
        c2_valid  = 1'b0;
        c2_data   = 32'd0;
        model_reset();
        tick();
        tick();
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check_outputs(4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        send(32'h0000_A503);
        send(32'h1000_0013);
        send(32'h2000_0000);
        send(32'h0000_0110);
        send(32'h1000_0020);
        check("err_cnt_three", 32'(err_cnt), 32'(model_err_cnt()));

        // Back-to-back words with cmd_valid held high; garbage presented while busy.
        tp_words[0] = 32'h0000_1101;
        tp_words[1] = 32'h1000_0005;
        tp_words[2] = 32'h0000_220C;
        tp_words[3] = 32'h3000_0000;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                cmd_valid = 1'b1;
                cmd_data  = (c % 2 == 0) ? tp_words[c / 2] : $urandom;
            end else begin
                cmd_valid = 1'b0;
            end
            if (c < 8) check("tp_ready", 32'(cmd_ready), 32'((c % 2) == 0));
            if (c >= 2 && c % 2 == 0) begin
                model_apply(tp_words[c / 2 - 1], e_upd, e_oupd, e_err);
                check_outputs(e_upd, e_oupd, e_err);
            end else if (c % 2 == 1) begin
                check("tp_gap_pulses", {26'd0, bank_upd, out_upd, err}, 32'd0);
            end
            tick();
        end

        for (int t = 0; t < 40; t++) send(rand_word());

        // Reset while a word is held in EXEC.
        send(32'h0000_7701);
        first_banks = bank_val;
        check("pre_rst_nonzero", 32'(first_banks != 32'd0), 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = 32'h0000_FF0F;
        tick();
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        model_reset();
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check_outputs(4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check("midrst_banks_hold", bank_val, 32'd0);
        check("midrst_upd_hold", 32'(bank_upd), 32'd0);

        send2(32'h0000_3304, 2'b00, 1'b1);
        send2(32'h0000_3300, 2'b00, 1'b0);
        send2(32'h0000_3302, 2'b10, 1'b0);
        check("nb2_bank_val", 32'(c2_bank_val), 32'h0000_3300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
